alu_seq_6_bit: RTL and testbench

//   Multi-cycle sequencer for the 6-bit CPU datapath. Accepts one register-register
//   ALU instruction at a time and runs it through the shared 6-bit logic/arith

---
 rtl/alu_seq_6_bit_pkg.sv | 26 ++
 rtl/alu_core_6_bit.sv | 35 +++
 rtl/alu_seq_6_bit.sv | 88 ++++++++
 tb/tb_alu_seq_6_bit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_6_bit_pkg.sv
// alu_seq_6_bit_pkg: shared widths, opcodes, sequencer states and flag bundle.
package alu_seq_6_bit_pkg;
  localparam int DW = 6;
  localparam int RW = 2;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;
  typedef struct packed {
    logic cf;
    logic sf;
    logic zf;
  } flags_t;
endpackage

// File: rtl/alu_core_6_bit.sv
// alu_core_6_bit: combinational 6-bit logic/arith unit with carry, sign and zero flags.
module alu_core_6_bit
  import alu_seq_6_bit_pkg::*;
(
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_res,
  output logic          o_cf,
  output logic          o_sf,
  output logic          o_zf
);
  logic [DW:0] w_sum;
  logic [DW:0] w_diff;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Bit DW of the widened difference is the unsigned borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  always_comb begin
    o_res = '0;
    o_cf  = 1'b0;
    case (op_t'(i_op))
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_NOT: o_res = ~i_b;
      OP_ADD: {o_cf, o_res} = w_sum;
      OP_SUB: {o_cf, o_res} = w_diff;
      OP_SHL: {o_cf, o_res} = {i_a, 1'b0};
      OP_SHR: {o_res, o_cf} = {1'b0, i_a};
      default: ;
    endcase
  end
  assign o_sf = o_res[DW-1];
  assign o_zf = (o_res == '0);
endmodule

// File: rtl/alu_seq_6_bit.sv
// alu_seq_6_bit: multi-cycle read/execute/writeback sequencer around a 4x6 register file.
module alu_seq_6_bit
  import alu_seq_6_bit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [6:0]    instr,
  output logic          instr_ready,
  input  logic          ld_valid,
  input  logic [RW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          cf,
  output logic          sf,
  output logic          zf,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  state_t               r_state;
  state_t               w_next;
  logic [3:0][DW-1:0]   r_regs;
  logic [2:0]           r_op;
  logic [RW-1:0]        r_rd;
  logic [RW-1:0]        r_rs;
  logic [DW-1:0]        r_a;
  logic [DW-1:0]        r_b;
  logic [DW-1:0]        r_res;
  flags_t               r_flags;
  logic [DW-1:0]        w_res;
  flags_t               w_flags;
  logic                 w_accept;
  alu_core_6_bit u_core (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_res (w_res),
    .o_cf  (w_flags.cf),
    .o_sf  (w_flags.sf),
    .o_zf  (w_flags.zf)
  );
  // A pending load blocks acceptance so the regfile never sees two writers.
  assign instr_ready = (r_state == S_IDLE) & ~ld_valid;
  assign w_accept    = instr_ready & instr_valid;
  assign done        = (r_state == S_WRITE);
  assign dbg_data    = r_regs[dbg_addr];
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (w_accept ? S_READ : S_IDLE) :
             r_state == S_READ ? S_EXEC :
             r_state == S_EXEC ? S_WRITE : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_regs  <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_flags <= '0;
      result  <= '0;
      cf      <= 1'b0;
      sf      <= 1'b0;
      zf      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && ld_valid) r_regs[ld_addr] <= ld_data;
      if (w_accept) {r_op, r_rd, r_rs} <= instr;
      if (r_state == S_READ) begin
        r_a <= r_regs[r_rd];
        r_b <= r_regs[r_rs];
      end
      if (r_state == S_EXEC) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
      if (r_state == S_WRITE) begin
        r_regs[r_rd]   <= r_res;
        result         <= r_res;
        {cf, sf, zf}   <= r_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_6_bit.sv
// tb_alu_seq_6_bit: directed self-checking bench for the 6-bit ALU sequencer.
module tb_alu_seq_6_bit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [6:0] instr = '0;
  logic       instr_ready;
  logic       ld_valid = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [5:0] ld_data = '0;
  logic       done;
  logic [5:0] result;
  logic       cf, sf, zf;
  logic [1:0] dbg_addr = '0;
  logic [5:0] dbg_data;
  int checks = 0;
  int errors = 0;
  int acc;

  alu_seq_6_bit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .done(done), .result(result), .cf(cf), .sf(sf),
    .zf(zf), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] a, input logic [5:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("R%0d", a), {2'b0, dbg_data}, {2'b0, exp});
  endtask

  task automatic do_ld(input logic [1:0] a, input logic [5:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [5:0] er, input logic ecf,
                       input logic esf, input logic ezf);
    instr_valid = 1'b1;
    instr = {op, rd, rs};
    #1 chk({tag, "_ready"}, {7'b0, instr_ready}, 8'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom_range(0, 127);
    chk({tag, "_done_read"}, {7'b0, done}, 8'd0);
    @(negedge clk);
    chk({tag, "_done_exec"}, {7'b0, done}, 8'd0);
    @(negedge clk);
    chk({tag, "_done_write"}, {7'b0, done}, 8'd1);
    @(negedge clk);
    chk({tag, "_done_after"}, {7'b0, done}, 8'd0);
    chk({tag, "_result"}, {2'b0, result}, {2'b0, er});
    chk({tag, "_flags"}, {5'b0, cf, sf, zf}, {5'b0, ecf, esf, ezf});
    chk_reg(rd, er);
  endtask

  initial begin
    #2;
    chk("rst_done", {7'b0, done}, 8'd0);
    chk("rst_result", {2'b0, result}, 8'd0);
    chk("rst_flags", {5'b0, cf, sf, zf}, 8'd0);
    chk_reg(2'd3, 6'h00);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_idle", {7'b0, instr_ready}, 8'd1);
    // basic OR
    do_ld(2'd0, 6'h2A);
    do_ld(2'd1, 6'h15);
    do_op("or", 3'b001, 2'd0, 2'd1, 6'h3F, 1'b0, 1'b1, 1'b0);
    // ADD wrap and SUB
    do_ld(2'd2, 6'h3F);
    do_ld(2'd3, 6'h01);
    do_op("add_wrap", 3'b100, 2'd2, 2'd3, 6'h00, 1'b1, 1'b0, 1'b1);
    do_op("sub_nb", 3'b101, 2'd3, 2'd2, 6'h01, 1'b0, 1'b0, 1'b0);
    // SUB borrow, SHR to zero
    do_ld(2'd0, 6'h05);
    do_ld(2'd1, 6'h06);
    do_op("sub_borrow", 3'b101, 2'd0, 2'd1, 6'h3F, 1'b1, 1'b1, 1'b0);
    do_op("shr", 3'b111, 2'd3, 2'd3, 6'h00, 1'b1, 1'b0, 1'b1);
    do_op("shl", 3'b110, 2'd0, 2'd0, 6'h3E, 1'b1, 1'b1, 1'b0);
    do_op("xor", 3'b010, 2'd1, 2'd0, 6'h38, 1'b0, 1'b1, 1'b0);
    do_op("not", 3'b011, 2'd2, 2'd1, 6'h07, 1'b0, 1'b0, 1'b0);
    do_op("and", 3'b000, 2'd1, 2'd2, 6'h00, 1'b0, 1'b0, 1'b1);
    // a load must not disturb flags or result
    do_ld(2'd3, 6'h2A);
    chk("ld_done", {7'b0, done}, 8'd0);
    chk("ld_flags", {5'b0, cf, sf, zf}, 8'b001);
    chk("ld_result", {2'b0, result}, 8'h00);
    chk_reg(2'd3, 6'h2A);
    // instr_valid held for 8 cycles: two accepts, two done pulses
    do_ld(2'd0, 6'h01);
    do_ld(2'd1, 6'h01);
    instr_valid = 1'b1;
    instr = {3'b100, 2'd0, 2'd1};
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("held_ready%0d", k), {7'b0, instr_ready}, {7'b0, k % 4 == 0});
      chk($sformatf("held_done%0d", k), {7'b0, done}, {7'b0, k % 4 == 3});
      if (instr_ready) acc++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_accepts", acc[7:0], 8'd2);
    chk_reg(2'd0, 6'h03);
    // load wins over simultaneous instr; load during EXEC ignored
    ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 6'h11;
    instr_valid = 1'b1; instr = {3'b100, 2'd2, 2'd3};
    #1 chk("coll_ready", {7'b0, instr_ready}, 8'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    #1 chk("coll_ready2", {7'b0, instr_ready}, 8'd1);
    chk_reg(2'd2, 6'h11);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 6'h2F;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("coll_done", {7'b0, done}, 8'd1);
    @(negedge clk);
    chk_reg(2'd1, 6'h01);
    chk_reg(2'd2, 6'h3B);
    chk("coll_flags", {5'b0, cf, sf, zf}, 8'b010);
    // reset during EXEC abandons the instruction
    instr_valid = 1'b1; instr = {3'b100, 2'd0, 2'd1};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_done", {7'b0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("post_rst_done%0d", k), {7'b0, done}, 8'd0);
      @(negedge clk);
    end
    #1 chk("post_rst_ready", {7'b0, instr_ready}, 8'd1);
    chk("post_rst_result", {2'b0, result}, 8'd0);
    chk("post_rst_flags", {5'b0, cf, sf, zf}, 8'd0);
    for (int a = 0; a < 4; a++) chk_reg(a[1:0], 6'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
